// File: rtl/i2c_tx_engine_pkg.sv
// Shared constants for the I2C write engine: FSM encodings, quarter-bit phases
// and the clocks-per-quarter derivation.
package i2c_tx_engine_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] BIT   = 3'd2;
    localparam logic [2:0] ACK   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int BYTES_PER_OP = 3;

    function automatic int quarter_clks(input int clk_hz, input int i2c_hz);
        return clk_hz / (4 * i2c_hz);
    endfunction

endpackage

// File: rtl/i2c_tx_engine_qtick.sv
// Quarter-bit timebase: counts Q clocks per quarter, advances a 2-bit phase on
// wrap, and holds while SCL is being stretched.
module i2c_qtick #(
    parameter int Q = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       stall,
    input  logic       last,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CW = (Q > 1) ? $clog2(Q) : 1;

    logic [CW-1:0] cnt;

    assign tick = !clr && !stall && (cnt == CW'(Q - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 2'd0;
        end else if (clr) begin
            cnt   <= '0;
            phase <= 2'd0;
        end else if (tick) begin
            cnt   <= '0;
            // Short sequences (START, STOP) restart the phase before reaching q3.
            phase <= last ? 2'd0 : phase + 2'd1;
        end else if (!stall) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_tx_engine.sv
// I2C master write engine: START, three bytes each followed by an ACK slot,
// STOP, then a four-phase op_start/op_done handshake. Open-drain SCL/SDA.
module i2c_tx_engine
    import i2c_tx_engine_pkg::*;
#(
    parameter int CLK_HZ = 27000000,
    parameter int I2C_HZ = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] address,
    input  logic [7:0] control,
    input  logic [7:0] data,
    input  logic       op_start,
    output logic       op_done,
    output logic       ack_err,
    output logic       busy,
    inout  wire        sck,
    inout  wire        sda
);

    localparam int Q = quarter_clks(CLK_HZ, I2C_HZ);

    if (Q < 1) begin : g_q_check
        $error("i2c_tx_engine: CLK_HZ must be at least 4*I2C_HZ");
    end

    logic [2:0]  state;
    logic [23:0] shreg;
    logic [1:0]  byte_idx;
    logic [2:0]  bit_idx;
    logic        nack;

    logic        tick;
    logic [1:0]  phase;
    logic        scl_hi;
    logic        scl_low;
    logic        sda_low;
    logic        stall;
    logic        clr;
    logic        last;

    always_comb begin
        scl_hi  = 1'b0;
        sda_low = 1'b0;
        case (state)
            START: begin
                scl_hi  = (phase == Q0);
                sda_low = 1'b1;
            end
            BIT: begin
                scl_hi  = phase[1];
                sda_low = !shreg[23];
            end
            ACK:  scl_hi = phase[1];
            STOP: begin
                scl_hi  = (phase != Q0);
                sda_low = (phase != Q2);
            end
            default: ;
        endcase
        scl_low = (state == START || state == BIT || state == ACK || state == STOP) && !scl_hi;
    end

    assign sck = scl_low ? 1'b0 : 1'bz;
    assign sda = sda_low ? 1'b0 : 1'bz;

    // A slave holding SCL low while we release it freezes the quarter counter.
    assign stall = scl_hi && !sck;
    assign clr   = (state == IDLE) || (state == DONE);
    assign last  = (state == START && phase == Q1) || (state == STOP && phase == Q2);

    i2c_qtick #(
        .Q(Q)
    ) u_qtick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .stall(stall),
        .last (last),
        .tick (tick),
        .phase(phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            byte_idx <= 2'd0;
            bit_idx  <= 3'd0;
            nack     <= 1'b0;
            op_done  <= 1'b0;
            ack_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_start && !op_done) begin
                        shreg    <= {address, control, data};
                        ack_err  <= 1'b0;
                        busy     <= 1'b1;
                        byte_idx <= 2'd0;
                        bit_idx  <= 3'd0;
                        state    <= START;
                    end
                end
                START: if (tick && phase == Q1) state <= BIT;
                BIT: begin
                    if (tick && phase == Q3) begin
                        shreg   <= {shreg[22:0], 1'b0};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= ACK;
                    end
                end
                ACK: begin
                    if (tick && phase == Q2) begin
                        nack <= sda;
                    end else if (tick && phase == Q3) begin
                        if (nack) begin
                            ack_err <= 1'b1;
                            state   <= STOP;
                        end else if (byte_idx == 2'(BYTES_PER_OP - 1)) begin
                            state <= STOP;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= BIT;
                        end
                    end
                end
                STOP: if (tick && phase == Q2) state <= DONE;
                DONE: begin
                    // First clock raises op_done; afterwards wait for op_start low.
                    if (!op_done) begin
                        op_done <= 1'b1;
                    end else if (!op_start) begin
                        op_done <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_tx_engine.sv
// Bench for i2c_tx_engine: pulled-up bus, ACKing slave decoder, directed and
// random writes checked against bus-level expectations.
module tb_i2c_tx_engine;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] address = 8'h00;
    logic [7:0] control = 8'h00;
    logic [7:0] data = 8'h00;
    logic       op_start = 1'b0;
    logic       op_done;
    logic       ack_err;
    logic       busy;

    wire scl_bus;
    wire sda_bus;
    pullup (scl_bus);
    pullup (sda_bus);

    logic slv_scl_low = 1'b0;
    logic slv_sda_low = 1'b0;
    assign scl_bus = slv_scl_low ? 1'b0 : 1'bz;
    assign sda_bus = slv_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_tx_engine #(
        .CLK_HZ(1600000),
        .I2C_HZ(100000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .control (control),
        .data    (data),
        .op_start(op_start),
        .op_done (op_done),
        .ack_err (ack_err),
        .busy    (busy),
        .sck     (scl_bus),
        .sda     (sda_bus)
    );

    // Slave: decodes START/STOP, shifts bytes on SCL rise, ACKs (or NACKs byte 0).
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;
    int         bitn = 0;
    int         byte_in_frame = 0;
    int         falls = 0;
    int         pulses = 0;
    int         starts = 0;
    int         stops = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] got[$];
    bit         nack_addr = 1'b0;

    always @(negedge clk) begin
        if (scl_bus && scl_p) begin
            if (!sda_bus && sda_p) begin
                starts++;
                bitn = -1;
                byte_in_frame = 0;
            end else if (sda_bus && !sda_p) begin
                stops++;
            end
        end
        if (scl_bus && !scl_p && bitn >= 0 && bitn < 8) sh = {sh[6:0], sda_bus};
        if (!scl_bus && scl_p) begin
            falls++;
            if (bitn >= 0) pulses++;
            bitn++;
            if (bitn == 8) begin
                got.push_back(sh);
                slv_sda_low = !(nack_addr && byte_in_frame == 0);
            end else if (bitn == 9) begin
                slv_sda_low = 1'b0;
                bitn = 0;
                byte_in_frame++;
            end
        end
        scl_p = scl_bus;
        sda_p = sda_bus;
    end

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold SCL low from the start of the 5th SCL-low interval until n clocks into
    // the following high quarter.
    task automatic stretch_scl(input int f0, input int n);
        for (int i = 0; i < 4000 && falls < f0 + 5; i++) begin
            @(negedge clk);
            #1;
        end
        slv_scl_low = 1'b1;
        repeat (2 * Q + n) @(posedge clk);
        #1;
        slv_scl_low = 1'b0;
    endtask

    task automatic do_txn(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d,
                          input bit nack, input int stretch, input int drop_at,
                          input int hold, input string name);
        logic [7:0] exp_b[3];
        int nb, quarters, exp_lat, lat;
        int starts0, stops0, pulses0, falls0, gbase;
        bit seen;
        exp_b[0] = a;
        exp_b[1] = c;
        exp_b[2] = d;
        nb       = nack ? 1 : 3;
        quarters = 2 + 4 * 9 * nb + 3;
        exp_lat  = quarters * Q + 1 + stretch;
        starts0  = starts;
        stops0   = stops;
        pulses0  = pulses;
        falls0   = falls;
        gbase    = got.size();
        nack_addr = nack;

        @(negedge clk);
        address  = a;
        control  = c;
        data     = d;
        op_start = 1'b1;
        if (stretch > 0) begin
            fork
                stretch_scl(falls0, stretch);
            join_none
        end
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) begin
                check({name, "/busy"}, busy, 1);
                check({name, "/start_sda"}, sda_bus, 0);
                check({name, "/start_scl"}, scl_bus, 1);
                address = 8'($urandom);
                control = 8'($urandom);
                data    = 8'($urandom);
            end
            if (lat == drop_at) op_start = 1'b0;
            if (op_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "/done_seen"}, seen, 1);
        if (!seen) begin
            op_start = 1'b0;
            return;
        end
        check({name, "/latency"}, lat - 1, exp_lat);
        check({name, "/ack_err"}, ack_err, nack);
        check({name, "/nbytes"}, got.size() - gbase, nb);
        for (int i = 0; i < nb && gbase + i < got.size(); i++)
            check({name, "/byte"}, got[gbase + i], exp_b[i]);
        check({name, "/pulses"}, pulses - pulses0, 9 * nb);
        check({name, "/starts"}, starts - starts0, 1);
        check({name, "/stops"}, stops - stops0, 1);

        if (op_start) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({name, "/done_held"}, op_done, 1);
            end
            op_start = 1'b0;
        end
        @(posedge clk);
        #1;
        check({name, "/done_fall"}, op_done, 0);
        check({name, "/busy_fall"}, busy, 0);
        repeat (10) @(posedge clk);
        #1;
        check({name, "/no_retrigger"}, starts - starts0, 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset/op_done", op_done, 0);
        check("reset/ack_err", ack_err, 0);
        check("reset/busy", busy, 0);
        check("reset/scl", scl_bus, 1);
        check("reset/sda", sda_bus, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        do_txn(8'h78, 8'h00, 8'h8D, 1'b0, 0, 0, 0, "w788d");
        for (int k = 0; k < 2; k++)
            do_txn({7'($urandom), 1'b0}, 8'($urandom), 8'($urandom), 1'b0, 0, 0, 0, "rand");
        do_txn({7'($urandom), 1'b0}, 8'($urandom), 8'($urandom), 1'b1, 0, 0, 0, "nack");
        do_txn(8'h78, 8'hA5, 8'h3C, 1'b0, 20, 0, 0, "stretch");
        do_txn({7'($urandom), 1'b0}, 8'($urandom), 8'($urandom), 1'b0, 0, 0, 50, "hold");
        do_txn({7'($urandom), 1'b0}, 8'($urandom), 8'($urandom), 1'b0, 0, 30, 0, "drop");

        // Reset in the middle of byte 1: bus must be released at once.
        @(negedge clk);
        address  = 8'h78;
        control  = 8'h40;
        data     = 8'hFF;
        op_start = 1'b1;
        repeat (170) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst/scl", scl_bus, 1);
        check("midrst/sda", sda_bus, 1);
        check("midrst/op_done", op_done, 0);
        check("midrst/busy", busy, 0);
        @(negedge clk);
        op_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        do_txn({7'($urandom), 1'b0}, 8'($urandom), 8'($urandom), 1'b0, 0, 0, 0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
